// File: rtl/life_pkg.sv
// Shared types and default geometry for the Life frame-buffer scheduler.
// Default board is 400x300 cells, addressed with 24-bit cell indices.
package life_pkg;

  localparam int P_N_DEF = 400;
  localparam int P_M_DEF = 300;
  localparam int CELLS   = P_N_DEF * P_M_DEF;
  localparam int ADDR_W  = 24;

  // Buffer indices; front resets to FB_A.
  localparam bit FB_A = 1'b0;
  localparam bit FB_B = 1'b1;

  typedef enum logic [2:0] {
    FB_IDLE,
    FB_CLEAR,
    FB_LOAD,
    FB_EVOLVE,
    FB_SWAP_WAIT
  } fb_state_t;

  function automatic int cells_of(input int n, input int m);
    return n * m;
  endfunction

endpackage

// File: rtl/life_fb_scheduler_if.sv
// RAM-side bus of the scheduler: one address/data/write-enable/read-data set per frame RAM.
// The scheduler is the master; the two RAM instances sit behind the slave modport.
interface life_fb_scheduler_if #(
  parameter int ADDR_W = life_pkg::ADDR_W
);

  logic [ADDR_W-1:0] ram_addr [2];
  logic              ram_data [2];
  logic              ram_wren [2];
  logic              ram_q    [2];

  modport master (output ram_addr, ram_data, ram_wren, input ram_q);
  modport slave  (input ram_addr, ram_data, ram_wren, output ram_q);

endinterface

// File: rtl/life_fb_sweep.sv
// Clear sweeper: walks 0..CELLS-1, one cell per enabled cycle, and flags the final cell.
// The counter wraps to 0 on its last step so every sweep starts from cell 0.
module life_fb_sweep #(
  parameter int ADDR_W = 24,
  parameter int CELLS  = 120000
) (
  input  logic              clk_vga,
  input  logic              reset_btn,
  input  logic              start,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CELLS - 1);

  logic [ADDR_W-1:0] cnt_reg;

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= last ? '0 : cnt_reg + ADDR_W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign last = en && (cnt_reg == LAST_A);

endmodule

// File: rtl/life_fb_scheduler.sv
// Ping-pong frame-buffer scheduler for Game of Life: arbitrates the two cell RAMs among
// VGA, Round, SD loader and clear sweep. Build option FB_VSYNC_SWAP_EN: swap only in vertical blank.
module life_fb_scheduler #(
  parameter int P_N    = life_pkg::P_N_DEF,
  parameter int P_M    = life_pkg::P_M_DEF,
  parameter int ADDR_W = life_pkg::ADDR_W
) (
  input  logic                clk_vga,
  input  logic                reset_btn,
  input  logic                evo_tick,
  input  logic                clear_req,
  input  logic                load_req,
  input  logic                load_we,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic                load_data,
  output logic                load_gnt,
  input  logic                vga_blank,
  input  logic [ADDR_W-1:0]   vga_addr,
  output logic                vga_q,
  output logic                rnd_start,
  input  logic                rnd_done,
  input  logic [ADDR_W-1:0]   rnd_raddr,
  output logic                rnd_q,
  input  logic [ADDR_W-1:0]   rnd_waddr,
  input  logic                rnd_wdata,
  input  logic                rnd_we,
  life_fb_scheduler_if.master ram,
  output logic                front,
  output logic                busy
);

  import life_pkg::*;

  localparam int                N_CELLS = cells_of(P_N, P_M);
  localparam logic [ADDR_W-1:0] LIMIT   = ADDR_W'(N_CELLS);

  fb_state_t         state_reg, state_next;
  logic              front_reg, phase_reg;
  logic              vga_own_reg, rnd_own_reg, rd_sel_reg;
  logic              vga_q_reg, rnd_q_reg;
  logic              swap_ok, swap, vga_slot, rnd_slot;
  logic              sweep_start, sweep_en, sweep_last;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              load_ok, rnd_ok;

`ifdef FB_VSYNC_SWAP_EN
  assign swap_ok = vga_blank;
`else
  logic unused_blank;
  assign swap_ok      = 1'b1;
  assign unused_blank = vga_blank;
`endif

  life_fb_sweep #(.ADDR_W(ADDR_W), .CELLS(N_CELLS)) u_sweep (
    .clk_vga   (clk_vga),
    .reset_btn (reset_btn),
    .start     (sweep_start),
    .en        (sweep_en),
    .cnt       (sweep_cnt),
    .last      (sweep_last)
  );

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) state_reg <= FB_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      FB_IDLE: begin
        if (clear_req)     state_next = FB_CLEAR;
        else if (load_req) state_next = FB_LOAD;
        else if (evo_tick) state_next = FB_EVOLVE;
      end
      FB_CLEAR:     if (sweep_last) state_next = FB_IDLE;
      FB_LOAD:      if (!load_req)  state_next = FB_IDLE;
      FB_EVOLVE: begin
        // A clear abandons the half-written back buffer; the front stays as shown.
        if (clear_req)     state_next = FB_CLEAR;
        else if (rnd_done) state_next = FB_SWAP_WAIT;
      end
      FB_SWAP_WAIT: if (swap_ok) state_next = FB_IDLE;
      default:      state_next = FB_IDLE;
    endcase
  end

  always_comb begin
    rnd_start = 1'b0;
    load_gnt  = 1'b0;
    busy      = 1'b1;
    sweep_en  = 1'b0;
    swap      = 1'b0;
    vga_slot  = 1'b0;
    rnd_slot  = 1'b0;
    unique case (state_reg)
      FB_IDLE: begin
        busy      = 1'b0;
        vga_slot  = 1'b1;
        rnd_start = evo_tick && !clear_req && !load_req;
      end
      FB_CLEAR: sweep_en = 1'b1;
      FB_LOAD:  load_gnt = 1'b1;
      FB_EVOLVE: begin
        vga_slot = !phase_reg;
        rnd_slot = phase_reg;
      end
      FB_SWAP_WAIT: begin
        vga_slot = 1'b1;
        swap     = swap_ok;
      end
      default: busy = 1'b1;
    endcase
  end

  assign sweep_start = (state_next == FB_CLEAR) && (state_reg != FB_CLEAR);
  assign load_ok     = load_addr < LIMIT;
  assign rnd_ok      = rnd_waddr < LIMIT;

  // rd_sel_reg remembers which RAM was addressed, so a swap cannot misroute in-flight read data.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      front_reg   <= FB_A;
      phase_reg   <= 1'b0;
      vga_own_reg <= 1'b0;
      rnd_own_reg <= 1'b0;
      rd_sel_reg  <= FB_A;
      vga_q_reg   <= 1'b0;
      rnd_q_reg   <= 1'b0;
    end else begin
      phase_reg   <= ~phase_reg;
      vga_own_reg <= vga_slot;
      rnd_own_reg <= rnd_slot;
      rd_sel_reg  <= front_reg;
      if (swap) front_reg <= ~front_reg;
      if (state_reg == FB_CLEAR) vga_q_reg <= 1'b0;
      else if (vga_own_reg)      vga_q_reg <= ram.ram_q[rd_sel_reg];
      if (rnd_own_reg) rnd_q_reg <= ram.ram_q[rd_sel_reg];
    end
  end

  assign front = front_reg;
  assign vga_q = vga_q_reg;
  assign rnd_q = rnd_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ram
      logic              is_front;
      logic [ADDR_W-1:0] addr_mux;
      logic              data_mux, wren_mux;

      assign is_front = (front_reg == 1'(gi));

      always_comb begin
        addr_mux = '0;
        data_mux = 1'b0;
        wren_mux = 1'b0;
        unique case (state_reg)
          FB_CLEAR: begin
            addr_mux = sweep_cnt;
            wren_mux = 1'b1;
          end
          FB_LOAD: begin
            addr_mux = load_addr;
            data_mux = load_data;
            wren_mux = load_we && load_ok;
          end
          FB_EVOLVE: begin
            if (is_front) begin
              addr_mux = phase_reg ? rnd_raddr : vga_addr;
            end else begin
              addr_mux = rnd_waddr;
              data_mux = rnd_wdata;
              wren_mux = rnd_we && rnd_ok;
            end
          end
          default: addr_mux = is_front ? vga_addr : '0;
        endcase
      end

      assign ram.ram_addr[gi] = addr_mux;
      assign ram.ram_data[gi] = data_mux;
      assign ram.ram_wren[gi] = wren_mux;
    end
  endgenerate

endmodule

// File: tb/tb_life_fb_scheduler.sv
// Directed-plus-random bench for life_fb_scheduler on a 4x3 board; two behavioural RAMs
// sit on the RAM bus and a golden cell image per buffer is built from the stimulus.
module tb_life_fb_scheduler;

  localparam int P_N   = 4;
  localparam int P_M   = 3;
  localparam int AW    = 24;
  localparam int CELLS = P_N * P_M;

  logic          clk_vga   = 1'b0;
  logic          reset_btn = 1'b1;
  logic          evo_tick  = 1'b0, clear_req = 1'b0, load_req = 1'b0, load_we = 1'b0;
  logic          load_data = 1'b0, vga_blank = 1'b0, rnd_done = 1'b0;
  logic          rnd_wdata = 1'b0, rnd_we = 1'b0;
  logic [AW-1:0] load_addr = '0, vga_addr = '0, rnd_raddr = '0, rnd_waddr = '0;
  logic          load_gnt, vga_q, rnd_start, rnd_q, front, busy;

  int vectors     = 0;
  int miscompares = 0;

  life_fb_scheduler_if #(.ADDR_W(AW)) ram_bus ();

  life_fb_scheduler #(.P_N(P_N), .P_M(P_M), .ADDR_W(AW)) dut (
    .clk_vga   (clk_vga),
    .reset_btn (reset_btn),
    .evo_tick  (evo_tick),
    .clear_req (clear_req),
    .load_req  (load_req),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_gnt  (load_gnt),
    .vga_blank (vga_blank),
    .vga_addr  (vga_addr),
    .vga_q     (vga_q),
    .rnd_start (rnd_start),
    .rnd_done  (rnd_done),
    .rnd_raddr (rnd_raddr),
    .rnd_q     (rnd_q),
    .rnd_waddr (rnd_waddr),
    .rnd_wdata (rnd_wdata),
    .rnd_we    (rnd_we),
    .ram       (ram_bus),
    .front     (front),
    .busy      (busy)
  );

  always #5 clk_vga = ~clk_vga;

  // Behavioural RAMs with registered read; reset fills them with 1s so a clear is visible.
  logic mem [2][CELLS];
  logic q_m [2];
  int   oob_writes = 0;
  int   wr_cnt [2] = '{0, 0};

  always @(posedge clk_vga) begin
    for (int i = 0; i < 2; i++) begin
      if (reset_btn) begin
        for (int c = 0; c < CELLS; c++) mem[i][c] <= 1'b1;
      end else if (ram_bus.ram_wren[i]) begin
        if (int'(ram_bus.ram_addr[i]) < CELLS) mem[i][int'(ram_bus.ram_addr[i])] <= ram_bus.ram_data[i];
        else oob_writes <= oob_writes + 1;
        wr_cnt[i] <= wr_cnt[i] + 1;
      end
      q_m[i] <= (int'(ram_bus.ram_addr[i]) < CELLS) ? mem[i][int'(ram_bus.ram_addr[i])] : 1'b0;
    end
  end

  assign ram_bus.ram_q[0] = q_m[0];
  assign ram_bus.ram_q[1] = q_m[1];

  // Golden image of each buffer and of which buffer is displayed.
  logic gold [2][CELLS];
  int   exp_front = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ones_in(input int r);
    int s = 0;
    for (int c = 0; c < CELLS; c++) s += (mem[r][c] === 1'b1) ? 1 : 0;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, a, a2, w0, w1;
    logic v;

    repeat (3) @(negedge clk_vga);
    check("rst_busy", busy, 0);
    check("rst_front", front, 0);
    check("rst_load_gnt", load_gnt, 0);
    check("rst_vga_q", vga_q, 0);
    check("rst_rnd_q", rnd_q, 0);
    check("rst_wren0", ram_bus.ram_wren[0], 0);
    check("rst_wren1", ram_bus.ram_wren[1], 0);
    reset_btn = 1'b0;

    // Clear and evo_tick together: clear wins, no Round start.
    @(negedge clk_vga);
    clear_req = 1'b1; evo_tick = 1'b1;
    #1 check("clr_beats_evo_rnd_start", rnd_start, 0);
    @(negedge clk_vga);
    clear_req = 1'b0; evo_tick = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk_vga); end
    check("clear_busy_cycles", n, CELLS);
    check("clear_front", front, 0);
    check("clear_ram0_ones", ones_in(0), 0);
    check("clear_ram1_ones", ones_in(1), 0);
    check("clear_vga_q", vga_q, 0);
    for (int c = 0; c < CELLS; c++) begin gold[0][c] = 1'b0; gold[1][c] = 1'b0; end

    // Loader: random writes (some out of range), then the directed cells.
    load_req = 1'b1;
    n = 0;
    do begin @(negedge clk_vga); n++; end while (!load_gnt && n < 10);
    check("load_gnt", load_gnt, 1);
    for (int k = 0; k < 20; k++) begin
      a = int'($urandom_range(0, CELLS + 3));
      v = 1'($urandom);
      load_we   = ($urandom_range(0, 3) != 0);
      load_addr = AW'(a);
      load_data = v;
      if (load_we && a < CELLS) begin gold[0][a] = v; gold[1][a] = v; end
      @(negedge clk_vga);
    end
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 5 : (k == 1) ? 11 : 12;
      load_we = 1'b1; load_addr = AW'(a); load_data = 1'b1;
      if (a < CELLS) begin gold[0][a] = 1'b1; gold[1][a] = 1'b1; end
      @(negedge clk_vga);
    end
    load_we = 1'b0; load_req = 1'b0;
    @(negedge clk_vga);
    check("load_exit_busy", busy, 0);
    check("load_exit_gnt", load_gnt, 0);
    check("load_oob_writes", oob_writes, 0);
    check("load_ram0_cell5", mem[0][5], 1);
    check("load_ram1_cell11", mem[1][11], 1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CELLS; c++)
        check($sformatf("load_ram%0d_cell%0d", r, c), mem[r][c], gold[r][c]);

    // VGA reads in IDLE: two-cycle address-to-vga_q path.
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom_range(0, CELLS - 1));
      vga_addr = AW'(a);
      repeat (2) @(negedge clk_vga);
      check($sformatf("idle_vga_cell%0d", a), vga_q, gold[exp_front][a]);
    end

    // Generation 1: Round reads front (RAM0) and writes back (RAM1).
    w0 = wr_cnt[0]; w1 = wr_cnt[1];
    evo_tick = 1'b1;
    #1 check("evo_rnd_start", rnd_start, 1);
    @(negedge clk_vga);
    evo_tick = 1'b0;
    check("evo_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      a  = int'($urandom_range(0, CELLS - 1));
      a2 = int'($urandom_range(0, CELLS - 1));
      vga_addr = AW'(a); rnd_raddr = AW'(a2);
      evo_tick = 1'b1; load_req = 1'b1;
      #1 check("evo_drop_rnd_start", rnd_start, 0);
      @(negedge clk_vga);
      evo_tick = 1'b0;
      check("evo_ignore_load_gnt", load_gnt, 0);
      repeat (3) @(negedge clk_vga);
      load_req = 1'b0;
      check($sformatf("evo_vga_cell%0d", a), vga_q, gold[0][a]);
      check($sformatf("evo_rnd_cell%0d", a2), rnd_q, gold[0][a2]);
    end
    for (int c = 0; c <= CELLS; c++) begin
      v = 1'($urandom);
      rnd_waddr = AW'(c); rnd_wdata = v; rnd_we = 1'b1;
      if (c < CELLS) gold[1][c] = v;
      @(negedge clk_vga);
    end
    rnd_we = 1'b0;
    check("evo_back_writes", wr_cnt[1] - w1, CELLS);
    check("evo_front_writes", wr_cnt[0] - w0, 0);
    check("evo_oob_writes", oob_writes, 0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CELLS; c++)
        check($sformatf("evo_ram%0d_cell%0d", r, c), mem[r][c], gold[r][c]);
    rnd_done = 1'b1;
    @(negedge clk_vga);
    rnd_done = 1'b0;
    check("swap_wait_busy", busy, 1);
    check("swap_wait_front", front, 0);
`ifdef FB_VSYNC_SWAP_EN
    repeat (50) @(negedge clk_vga);
    check("vsync_hold_front", front, 0);
    check("vsync_hold_busy", busy, 1);
    vga_blank = 1'b1;
`endif
    @(negedge clk_vga);
    vga_blank = 1'b0;
    exp_front = 1;
    check("swap_front", front, exp_front);
    check("swap_busy", busy, 0);
    repeat (2) @(negedge clk_vga);
    check("no_queued_evo_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      a = int'($urandom_range(0, CELLS - 1));
      vga_addr = AW'(a);
      repeat (2) @(negedge clk_vga);
      check($sformatf("gen1_vga_cell%0d", a), vga_q, gold[exp_front][a]);
    end

    // Generation 2 aborted by clear: front must survive, both RAMs zeroed.
    evo_tick = 1'b1;
    #1 check("evo2_rnd_start", rnd_start, 1);
    @(negedge clk_vga);
    evo_tick = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rnd_waddr = AW'(c); rnd_wdata = 1'b1; rnd_we = 1'b1;
      @(negedge clk_vga);
    end
    rnd_we = 1'b0; clear_req = 1'b1;
    @(negedge clk_vga);
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk_vga); end
    check("abort_clear_cycles", n, CELLS);
    check("abort_front", front, 1);
    check("abort_ram0_ones", ones_in(0), 0);
    check("abort_ram1_ones", ones_in(1), 0);
    check("abort_vga_q", vga_q, 0);

    // Asynchronous reset in the middle of EVOLVE.
    evo_tick = 1'b1;
    @(negedge clk_vga);
    evo_tick = 1'b0;
    rnd_waddr = AW'(3); rnd_wdata = 1'b1; rnd_we = 1'b1;
    #1 check("pre_reset_back_wren", ram_bus.ram_wren[0], 1);
    #2 reset_btn = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_front", front, 0);
    check("async_rst_wren0", ram_bus.ram_wren[0], 0);
    check("async_rst_wren1", ram_bus.ram_wren[1], 0);
    @(negedge clk_vga);
    rnd_we = 1'b0; reset_btn = 1'b0;
    @(negedge clk_vga);
    check("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
